// File: rtl/tmr_cnt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tmr_cnt_gen
// Purpose  : Timer count generator. Owns the TCNT counter and its clock-select
//            prescaler. TCNT steps up or down by one (modulo 2^DATA_WIDTH) on
//            each prescaler tick and can be parallel-loaded from TDR. A
//            one-cycle strobe plus the step direction qualify every stepped
//            value for the downstream overflow/underflow detector.
// Ports    : pclk          - system clock
//            preset_n      - asynchronous active-low reset
//            TDR           - parallel load value
//            TCR           - control: [7] load, [5] up_down (1 = down),
//                            [4] en, [1:0] cks (divide by 2/4/8/16)
//            TCNT          - registered counter value
//            count_enable  - high in the first cycle a stepped TCNT is visible
//            count_up_down - direction of the step flagged by count_enable
// Revision : 1.0 - initial release
// ============================================================================
module tmr_cnt_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 4
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic [DATA_WIDTH-1:0] TDR,
    input  logic [DATA_WIDTH-1:0] TCR,
    output logic [DATA_WIDTH-1:0] TCNT,
    output logic                  count_enable,
    output logic                  count_up_down
);

    localparam logic [DIV_WIDTH-1:0]  c_div_one  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_data_one = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Control field decode
    logic       w_load;
    logic       w_dn;
    logic       w_en;
    logic [1:0] w_cks;
    logic       w_unused_tcr;

    assign w_load       = TCR[7];
    assign w_dn         = TCR[5];
    assign w_en         = TCR[4];
    assign w_cks        = TCR[1:0];
    assign w_unused_tcr = ^{TCR[6], TCR[3:2]};

    // State
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic [DATA_WIDTH-1:0] tcnt_q,    tcnt_d;
    logic                  cen_q,     cen_d;
    logic                  cud_q,     cud_d;

    // Prescaler mask: the low (cks+1) bits set, i.e. (2 << cks) - 1.
    logic [DIV_WIDTH-1:0] w_mask;
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            if (i <= int'(w_cks)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    // A tick is the last cycle of a prescale period. The mask is applied to
    // the free-running div_cnt, so a cks change takes effect without
    // clearing the prescaler.
    logic w_tick;
    assign w_tick = w_en & ~w_load & ((div_cnt_q & w_mask) == w_mask);

    always_comb begin
        div_cnt_d = div_cnt_q;
        tcnt_d    = tcnt_q;
        cen_d     = 1'b0;
        cud_d     = cud_q;
        if (w_load) begin
            // Load overrides everything and never produces a strobe.
            tcnt_d    = TDR;
            div_cnt_d = '0;
        end else if (!w_en) begin
            // Halt: restart the full prescale period on re-enable.
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + c_div_one;
            if (w_tick) begin
                tcnt_d = w_dn ? (tcnt_q - c_data_one) : (tcnt_q + c_data_one);
                cen_d  = 1'b1;
                cud_d  = w_dn;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_cnt_q <= '0;
            tcnt_q    <= '0;
            cen_q     <= 1'b0;
            cud_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tcnt_q    <= tcnt_d;
            cen_q     <= cen_d;
            cud_q     <= cud_d;
        end
    end

    assign TCNT          = tcnt_q;
    assign count_enable  = cen_q;
    assign count_up_down = cud_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_cnt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_cnt_gen
// Purpose  : Self-checking bench for tmr_cnt_gen: table-driven vectors,
//            hand-written corner sequences and randomized control traffic
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_cnt_gen;

    logic       pclk;
    logic       preset_n;
    logic [7:0] TDR;
    logic [7:0] TCR;
    logic [7:0] TCNT;
    logic       count_enable;
    logic       count_up_down;

    tmr_cnt_gen #(
        .DATA_WIDTH (8),
        .DIV_WIDTH  (4)
    ) u_dut (
        .pclk          (pclk),
        .preset_n      (preset_n),
        .TDR           (TDR),
        .TCR           (TCR),
        .TCNT          (TCNT),
        .count_enable  (count_enable),
        .count_up_down (count_up_down)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks;
    int n_err;

    // Reference model: counter value, prescale phase, last strobe/direction.
    int m_tcnt;
    int m_phase;
    bit m_ce;
    bit m_ud;

    task automatic model_reset();
        m_tcnt  = 0;
        m_phase = 0;
        m_ce    = 0;
        m_ud    = 0;
    endtask

    // One clock of the timer: a step happens when the cycle completes a
    // period of (2 << cks) enabled cycles.
    task automatic model_step(input logic [7:0] tdr, input logic [7:0] tcr);
        int period;
        period = 2 << tcr[1:0];
        if (tcr[7]) begin
            m_tcnt  = int'(tdr);
            m_phase = 0;
            m_ce    = 0;
        end else if (!tcr[4]) begin
            m_phase = 0;
            m_ce    = 0;
        end else begin
            if ((m_phase + 1) % period == 0) begin
                m_tcnt = (m_tcnt + (tcr[5] ? 255 : 1)) % 256;
                m_ce   = 1;
                m_ud   = tcr[5];
            end else begin
                m_ce = 0;
            end
            m_phase = (m_phase + 1) % 16;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock, then compare the DUT against the model.
    task automatic step(input string nm);
        @(posedge pclk);
        model_step(TDR, TCR);
        #1;
        chk({nm, " tcnt"}, int'(TCNT), m_tcnt);
        chk({nm, " ce"},   int'(count_enable), int'(m_ce));
        chk({nm, " ud"},   int'(count_up_down), int'(m_ud));
    endtask

    // Compare DUT outputs against hand-derived constants.
    task automatic expect_out(input string nm, input int t, input int ce, input int ud);
        chk({nm, " tcnt"}, int'(TCNT), t);
        chk({nm, " ce"},   int'(count_enable), ce);
        chk({nm, " ud"},   int'(count_up_down), ud);
    endtask

    task automatic drive(input logic [7:0] tdr, input logic [7:0] tcr);
        TDR = tdr;
        TCR = tcr;
    endtask

    typedef struct {
        logic [7:0] tdr;
        logic [7:0] tcr;
        logic [7:0] tcnt;
        logic       ce;
        logic       ud;
    } vec_t;

    vec_t tbl[10];

    logic [1:0] r_cks;
    logic       r_dn;
    logic       r_en;
    logic [7:0] r_tcr;

    initial begin
        n_checks = 0;
        n_err    = 0;
        model_reset();
        TDR      = 8'h00;
        TCR      = 8'h00;
        preset_n = 1'b1;
        #2 preset_n = 1'b0;
        #1 expect_out("reset", 0, 0, 0);
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;

        // Up count, cks=0, through the 0xFF -> 0x00 wrap.
        tbl[0] = '{8'hFD, 8'h80, 8'hFD, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h10, 8'hFD, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 8'h10, 8'hFE, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 8'h10, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h10, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 8'h10, 8'hFF, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 8'h10, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h10, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{8'h00, 8'h10, 8'h01, 1'b1, 1'b0};
        tbl[9] = '{8'h00, 8'h10, 8'h01, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].tdr, tbl[i].tcr);
            step("up_tbl");
            expect_out($sformatf("up_tbl[%0d]", i), int'(tbl[i].tcnt),
                       int'(tbl[i].ce), int'(tbl[i].ud));
        end

        // Down count, cks=3: steps 16 cycles apart, 0x01 -> 0x00 -> 0xFF.
        drive(8'h01, 8'h80); step("dn_load");
        drive(8'h00, 8'h33);
        for (int i = 0; i < 15; i++) step("dn_wait1");
        expect_out("dn_before1", 8'h01, 0, 0);
        step("dn_step1");
        expect_out("dn_step1", 8'h00, 1, 1);
        for (int i = 0; i < 15; i++) step("dn_wait2");
        expect_out("dn_before2", 8'h00, 0, 1);
        step("dn_step2");
        expect_out("dn_step2", 8'hFF, 1, 1);

        // Load on a tick cycle with TCNT=0xFF wins and never strobes.
        drive(8'hFE, 8'h80); step("lp_load");
        drive(8'h00, 8'h10); step("lp_a"); step("lp_b");
        expect_out("lp_ff", 8'hFF, 1, 0);
        step("lp_c");
        drive(8'h00, 8'h90); step("lp_tickload");
        expect_out("lp_tickload", 8'h00, 0, 0);
        drive(8'h00, 8'h10); step("lp_d");
        expect_out("lp_d", 8'h00, 0, 0);
        step("lp_e");
        expect_out("lp_e", 8'h01, 1, 0);

        // Halt for 5 cycles mid-period, then a full 8-cycle period on resume.
        drive(8'h10, 8'h82); step("hr_load");
        drive(8'h00, 8'h12);
        for (int i = 0; i < 3; i++) step("hr_run");
        drive(8'h00, 8'h02);
        for (int i = 0; i < 5; i++) begin
            step("hr_halt");
            expect_out("hr_halt", 8'h10, 0, 0);
        end
        drive(8'h00, 8'h12);
        for (int i = 0; i < 7; i++) step("hr_wait");
        expect_out("hr_before", 8'h10, 0, 0);
        step("hr_step");
        expect_out("hr_step", 8'h11, 1, 0);

        // Direction flip between ticks, cks=1.
        drive(8'h80, 8'h81); step("df_load");
        drive(8'h00, 8'h11);
        for (int i = 0; i < 4; i++) step("df_up");
        expect_out("df_up", 8'h81, 1, 0);
        drive(8'h00, 8'h31);
        for (int i = 0; i < 3; i++) step("df_wait");
        expect_out("df_before", 8'h81, 0, 0);
        step("df_dn");
        expect_out("df_dn", 8'h80, 1, 1);

        // Asynchronous reset mid-count with TCNT=0x37 and a live strobe.
        drive(8'h38, 8'h80); step("ar_load");
        drive(8'h00, 8'h30); step("ar_a"); step("ar_b");
        expect_out("ar_pre", 8'h37, 1, 1);
        #2 preset_n = 1'b0;
        model_reset();
        #1 expect_out("ar_async", 0, 0, 0);
        @(negedge pclk);
        preset_n = 1'b1;
        for (int i = 0; i < 4; i++) step("ar_post");

        // Randomized control traffic against the model.
        r_cks = 2'd0;
        r_dn  = 1'b0;
        r_en  = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) r_cks = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) r_dn  = ~r_dn;
            if ($urandom_range(0, 15) == 0) r_en  = ~r_en;
            r_tcr      = 8'($urandom);
            r_tcr[7]   = ($urandom_range(0, 24) == 0);
            r_tcr[5]   = r_dn;
            r_tcr[4]   = r_en;
            r_tcr[1:0] = r_cks;
            drive(8'($urandom), r_tcr);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
